// File: rtl/dcache_pkg.sv
// Shared types and constants for the dcache tag store controller.
package dcache_pkg;

  localparam int unsigned DCACHE_TAG_WIDTH             = 20;
  localparam int unsigned DCACHE_TAG_STORE_DATA_WIDTH  = 32;
  localparam int unsigned TAG_STORE_VALID_BIT_POSITION = 31;
  localparam int unsigned DCACHE_NUM_WORDS             = 64;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CMP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FILL,
    ST_FLUSH
  } tag_ctrl_state_e;

  // Tag store word: tag in the LSBs, valid flag at its fixed position, rest zero.
  function automatic logic [DCACHE_TAG_STORE_DATA_WIDTH-1:0] make_tag_word(
    input logic [DCACHE_TAG_WIDTH-1:0] tag,
    input logic                        valid
  );
    logic [DCACHE_TAG_STORE_DATA_WIDTH-1:0] word;
    word                               = '0;
    word[DCACHE_TAG_WIDTH-1:0]         = tag;
    word[TAG_STORE_VALID_BIT_POSITION] = valid;
    return word;
  endfunction

endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// Lookup, miss, flush and tag store SRAM signals of the dcache tag controller.
interface dcache_tag_ctrl_if
  import dcache_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = DCACHE_TAG_WIDTH,
  parameter int unsigned DATA_WIDTH = DCACHE_TAG_STORE_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = DCACHE_NUM_WORDS
) ();

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [IDX_W-1:0]      req_index_i;
  logic [TAG_WIDTH-1:0]  req_tag_i;
  logic                  rsp_valid_o;
  logic                  rsp_hit_o;
  logic                  miss_valid_o;
  logic                  miss_ready_i;
  logic [IDX_W-1:0]      miss_index_o;
  logic [TAG_WIDTH-1:0]  miss_tag_o;
  logic                  fill_done_i;
  logic                  flush_i;
  logic                  flush_done_o;
  logic                  ts_en_o;
  logic                  ts_we_o;
  logic [BE_W-1:0]       ts_be_o;
  logic [IDX_W-1:0]      ts_addr_o;
  logic [DATA_WIDTH-1:0] ts_wdata_o;
  logic [DATA_WIDTH-1:0] ts_rdata_i;

  // The tag controller is the master: it initiates all tag store accesses.
  modport master (
    input  req_valid_i, req_index_i, req_tag_i, miss_ready_i, fill_done_i, flush_i,
           ts_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, miss_valid_o, miss_index_o, miss_tag_o,
           flush_done_o, ts_en_o, ts_we_o, ts_be_o, ts_addr_o, ts_wdata_o
  );

  modport slave (
    output req_valid_i, req_index_i, req_tag_i, miss_ready_i, fill_done_i, flush_i,
           ts_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, miss_valid_o, miss_index_o, miss_tag_o,
           flush_done_o, ts_en_o, ts_we_o, ts_be_o, ts_addr_o, ts_wdata_o
  );

endinterface

// File: rtl/dcache_tag_ctrl.sv
// Dcache tag store initiator: lookup/compare, miss hand-off, refill tag write and
// invalidate sweeps after reset and on flush.
module dcache_tag_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = DCACHE_TAG_WIDTH,
  parameter int unsigned DATA_WIDTH = DCACHE_TAG_STORE_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = DCACHE_NUM_WORDS,
  parameter int unsigned VALID_POS  = TAG_STORE_VALID_BIT_POSITION
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dcache_tag_ctrl_if.master bus
);

  localparam int unsigned     IDX_W    = $clog2(NUM_WORDS);
  localparam int unsigned     BE_W     = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  tag_ctrl_state_e       state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  flush_pend_q, flush_pend_d;

  logic                  hit_c;
  logic                  req_ready_c, rsp_valid_c, rsp_hit_c, miss_valid_c, flush_done_c;
  logic                  ts_en_c, ts_we_c;
  logic [IDX_W-1:0]      ts_addr_c;
  logic [DATA_WIDTH-1:0] ts_wdata_c;
  logic                  unused_rdata;

  // Only the tag LSBs and the valid flag of the returned word matter.
  assign hit_c        = bus.ts_rdata_i[VALID_POS] && (bus.ts_rdata_i[TAG_WIDTH-1:0] == tag_q);
  assign unused_rdata = ^bus.ts_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      index_q      <= '0;
      tag_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      index_q      <= index_d;
      tag_q        <= tag_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    index_d      = index_q;
    tag_d        = tag_q;
    flush_pend_d = flush_pend_q;
    req_ready_c  = 1'b0;
    rsp_valid_c  = 1'b0;
    rsp_hit_c    = 1'b0;
    miss_valid_c = 1'b0;
    flush_done_c = 1'b0;
    ts_en_c      = 1'b0;
    ts_we_c      = 1'b0;
    ts_addr_c    = cnt_q;
    ts_wdata_c   = '0;

    unique case (state_q)
      ST_INIT, ST_FLUSH: begin
        ts_en_c = 1'b1;
        ts_we_c = 1'b1;
        cnt_d   = IDX_W'(cnt_q + 1'b1);
        if (cnt_q == LAST_IDX) begin
          state_d      = ST_IDLE;
          flush_done_c = (state_q == ST_FLUSH);
        end
      end
      ST_IDLE: begin
        // A flush wins over a simultaneous lookup; the lookup is simply not accepted.
        if (flush_pend_q || bus.flush_i) begin
          state_d      = ST_FLUSH;
          flush_pend_d = 1'b0;
          cnt_d        = '0;
        end else begin
          req_ready_c = 1'b1;
          if (bus.req_valid_i) begin
            ts_en_c   = 1'b1;
            ts_addr_c = bus.req_index_i;
            index_d   = bus.req_index_i;
            tag_d     = bus.req_tag_i;
            state_d   = ST_CMP;
          end
        end
      end
      ST_CMP: begin
        rsp_valid_c = 1'b1;
        rsp_hit_c   = hit_c;
        state_d     = hit_c ? ST_IDLE : ST_MISS_REQ;
      end
      ST_MISS_REQ: begin
        miss_valid_c = 1'b1;
        if (bus.miss_ready_i) begin
          state_d = bus.fill_done_i ? ST_FILL : ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        if (bus.fill_done_i) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        ts_en_c                    = 1'b1;
        ts_we_c                    = 1'b1;
        ts_addr_c                  = index_q;
        ts_wdata_c[TAG_WIDTH-1:0]  = tag_q;
        ts_wdata_c[VALID_POS]      = 1'b1;
        state_d                    = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // Flushes arriving mid-transaction wait for the next IDLE; during sweeps they merge.
    if (bus.flush_i && (state_q inside {ST_CMP, ST_MISS_REQ, ST_MISS_WAIT, ST_FILL})) begin
      flush_pend_d = 1'b1;
    end
  end

  // Gating with rst_ni keeps the SRAM quiet while reset is held in INIT.
  assign bus.req_ready_o  = req_ready_c;
  assign bus.rsp_valid_o  = rsp_valid_c;
  assign bus.rsp_hit_o    = rsp_hit_c;
  assign bus.miss_valid_o = miss_valid_c;
  assign bus.miss_index_o = index_q;
  assign bus.miss_tag_o   = tag_q;
  assign bus.flush_done_o = flush_done_c;
  assign bus.ts_en_o      = ts_en_c & rst_ni;
  assign bus.ts_we_o      = ts_we_c & rst_ni;
  assign bus.ts_be_o      = (ts_we_c && rst_ni) ? {BE_W{1'b1}} : {BE_W{1'b0}};
  assign bus.ts_addr_o    = ts_addr_c;
  assign bus.ts_wdata_o   = ts_wdata_c;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Directed bench for dcache_tag_ctrl with a small negedge-addressed tag store model.
module tb_dcache_tag_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dcache_tag_ctrl_if #(.TAG_WIDTH(20), .DATA_WIDTH(32), .NUM_WORDS(16)) bus ();

  dcache_tag_ctrl #(
    .TAG_WIDTH (20),
    .DATA_WIDTH(32),
    .NUM_WORDS (16),
    .VALID_POS (31)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Tag store: address sampled on negedge, write committed on posedge.
  logic [31:0] mem [16];
  logic [3:0]  addr_q;

  initial begin
    addr_q = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h8000_002A;
  end

  always @(negedge clk) if (bus.ts_en_o) addr_q <= bus.ts_addr_o;

  always @(posedge clk) begin
    if (bus.ts_en_o && bus.ts_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ts_be_o[b]) mem[addr_q][8*b +: 8] <= bus.ts_wdata_o[8*b +: 8];
      end
    end
  end

  assign bus.ts_rdata_i = mem[addr_q];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [3:0] idx, input logic [19:0] tag,
                        output logic acc, output logic rv, output logic hit);
    bus.req_valid_i = 1'b1;
    bus.req_index_i = idx;
    bus.req_tag_i   = tag;
    @(negedge clk);
    acc = bus.req_ready_o && bus.ts_en_o && !bus.ts_we_o && (bus.ts_addr_o == idx);
    step();
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    rv  = bus.rsp_valid_o;
    hit = bus.rsp_hit_o;
    step();
  endtask

  // Sixteen invalidate writes, then IDLE with req_ready_o high.
  task automatic test_sweep(input string name, input bit is_flush, output int pulses);
    logic [43:0] got, exp;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      got = {bus.ts_en_o, bus.ts_we_o, bus.ts_be_o, bus.ts_addr_o, bus.ts_wdata_o,
             bus.req_ready_o, bus.flush_done_o};
      exp = {1'b1, 1'b1, 4'hF, 4'(i), 32'h0, 1'b0, is_flush && (i == 15)};
      if (bus.flush_done_o) pulses++;
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s_write%0d: got %h expected %h", name, i, got, exp);
      end
      step();
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready_o, bus.ts_en_o, bus.flush_done_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s_idle: got ready/en/done %b expected 100", name,
               {bus.req_ready_o, bus.ts_en_o, bus.flush_done_o});
    end
    step();
  endtask

  task automatic test_reset();
    int pulses;
    bus.req_valid_i  = 1'b0;
    bus.req_index_i  = '0;
    bus.req_tag_i    = '0;
    bus.miss_ready_i = 1'b0;
    bus.fill_done_i  = 1'b0;
    bus.flush_i      = 1'b0;
    rst_n            = 1'b0;
    repeat (2) step();
    @(negedge clk);
    n_cmp++;
    if ({bus.ts_en_o, bus.ts_we_o, bus.ts_be_o, bus.req_ready_o, bus.rsp_valid_o,
         bus.miss_valid_o, bus.flush_done_o} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {bus.ts_en_o, bus.ts_we_o, bus.ts_be_o, bus.req_ready_o, bus.rsp_valid_o,
                bus.miss_valid_o, bus.flush_done_o});
    end
    step();
    rst_n = 1'b1;
    test_sweep("init", 1'b0, pulses);
  endtask

  task automatic test_miss_fill();
    logic acc, rv, hit;
    lookup(4'd3, 20'h2A, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b110) begin
      n_bad++;
      $display("FAIL miss_lookup: got acc/rsp/hit %b expected 110", {acc, rv, hit});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.miss_valid_o, bus.miss_index_o, bus.miss_tag_o, bus.req_ready_o, bus.rsp_valid_o}
        !== {1'b1, 4'd3, 20'h0002A, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL miss_req: got valid %b idx %0d tag %h expected 1 3 0002a",
               bus.miss_valid_o, bus.miss_index_o, bus.miss_tag_o);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.miss_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL miss_hold: got miss_valid %b expected 1", bus.miss_valid_o);
    end
    step();
    bus.miss_ready_i = 1'b1;
    step();
    bus.miss_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.miss_valid_o, bus.ts_en_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL miss_wait: got miss_valid/en %b expected 00", {bus.miss_valid_o, bus.ts_en_o});
    end
    step();
    bus.fill_done_i = 1'b1;
    step();
    bus.fill_done_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ts_en_o, bus.ts_we_o, bus.ts_be_o, bus.ts_addr_o, bus.ts_wdata_o}
        !== {1'b1, 1'b1, 4'hF, 4'd3, 32'h8000_002A}) begin
      n_bad++;
      $display("FAIL fill_write: got en %b we %b be %h addr %0d wdata %h expected 1 1 f 3 8000002a",
               bus.ts_en_o, bus.ts_we_o, bus.ts_be_o, bus.ts_addr_o, bus.ts_wdata_o);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready_o, bus.ts_en_o, bus.miss_valid_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL fill_idle: got ready/en/miss %b expected 100",
               {bus.req_ready_o, bus.ts_en_o, bus.miss_valid_o});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic acc, rv, hit;
    lookup(4'd3, 20'h2A, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b111) begin
      n_bad++;
      $display("FAIL hit_3_2a: got acc/rsp/hit %b expected 111", {acc, rv, hit});
    end
    lookup(4'd3, 20'h2B, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b110) begin
      n_bad++;
      $display("FAIL miss_3_2b: got acc/rsp/hit %b expected 110", {acc, rv, hit});
    end
    // Handshake and fill completion in the same cycle go straight to FILL.
    bus.miss_ready_i = 1'b1;
    bus.fill_done_i  = 1'b1;
    step();
    bus.miss_ready_i = 1'b0;
    bus.fill_done_i  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ts_en_o, bus.ts_we_o, bus.ts_addr_o, bus.ts_wdata_o}
        !== {1'b1, 1'b1, 4'd3, 32'h8000_002B}) begin
      n_bad++;
      $display("FAIL fast_fill: got en %b we %b addr %0d wdata %h expected 1 1 3 8000002b",
               bus.ts_en_o, bus.ts_we_o, bus.ts_addr_o, bus.ts_wdata_o);
    end
    step();
    lookup(4'd3, 20'h2B, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b111) begin
      n_bad++;
      $display("FAIL hit_3_2b: got acc/rsp/hit %b expected 111", {acc, rv, hit});
    end
    // Matching tag bits with the valid flag clear must still miss.
    lookup(4'd4, 20'h0, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b110) begin
      n_bad++;
      $display("FAIL invalid_4_0: got acc/rsp/hit %b expected 110", {acc, rv, hit});
    end
    bus.miss_ready_i = 1'b1;
    bus.fill_done_i  = 1'b1;
    step();
    bus.miss_ready_i = 1'b0;
    bus.fill_done_i  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ts_addr_o, bus.ts_wdata_o} !== {4'd4, 32'h8000_0000}) begin
      n_bad++;
      $display("FAIL fill_4_0: got addr %0d wdata %h expected 4 80000000", bus.ts_addr_o, bus.ts_wdata_o);
    end
    step();
    lookup(4'd4, 20'h0, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b111) begin
      n_bad++;
      $display("FAIL hit_4_0: got acc/rsp/hit %b expected 111", {acc, rv, hit});
    end
  endtask

  task automatic test_flush_with_req();
    logic acc, rv, hit;
    int   pulses;
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_index_i = 4'd3;
    bus.req_tag_i   = 20'h2B;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready_o, bus.ts_en_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL flush_prio: got ready/en %b expected 00", {bus.req_ready_o, bus.ts_en_o});
    end
    step();
    bus.flush_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    test_sweep("flush", 1'b1, pulses);
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL flush_done_count: got %0d expected 1", pulses);
    end
    lookup(4'd3, 20'h2B, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b110) begin
      n_bad++;
      $display("FAIL flushed_3_2b: got acc/rsp/hit %b expected 110", {acc, rv, hit});
    end
  endtask

  task automatic test_flush_in_miss();
    logic acc, rv, hit;
    int   pulses;
    bus.miss_ready_i = 1'b1;
    step();
    bus.miss_ready_i = 1'b0;
    bus.flush_i      = 1'b1;
    step();
    bus.flush_i      = 1'b0;
    bus.fill_done_i  = 1'b1;
    step();
    bus.fill_done_i  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ts_en_o, bus.ts_we_o, bus.ts_addr_o, bus.ts_wdata_o, bus.flush_done_o}
        !== {1'b1, 1'b1, 4'd3, 32'h8000_002B, 1'b0}) begin
      n_bad++;
      $display("FAIL pend_fill: got en %b we %b addr %0d wdata %h done %b expected 1 1 3 8000002b 0",
               bus.ts_en_o, bus.ts_we_o, bus.ts_addr_o, bus.ts_wdata_o, bus.flush_done_o);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready_o, bus.ts_en_o, bus.flush_done_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL pend_idle: got ready/en/done %b expected 000",
               {bus.req_ready_o, bus.ts_en_o, bus.flush_done_o});
    end
    step();
    test_sweep("pend_flush", 1'b1, pulses);
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL pend_done_count: got %0d expected 1", pulses);
    end
    lookup(4'd3, 20'h2B, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b110) begin
      n_bad++;
      $display("FAIL pend_flushed_3_2b: got acc/rsp/hit %b expected 110", {acc, rv, hit});
    end
  endtask

  task automatic test_reset_mid();
    logic acc, rv, hit;
    int   pulses;
    @(negedge clk);
    n_cmp++;
    if (bus.miss_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_miss: got miss_valid %b expected 1", bus.miss_valid_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.miss_valid_o, bus.ts_en_o, bus.req_ready_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_reset: got miss/en/ready %b expected 000",
               {bus.miss_valid_o, bus.ts_en_o, bus.req_ready_o});
    end
    step();
    step();
    rst_n = 1'b1;
    test_sweep("reinit", 1'b0, pulses);
    lookup(4'd4, 20'h0, acc, rv, hit);
    n_cmp++;
    if ({acc, rv, hit} !== 3'b110) begin
      n_bad++;
      $display("FAIL reinit_4_0: got acc/rsp/hit %b expected 110", {acc, rv, hit});
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_flush_with_req();
    test_flush_in_miss();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
